// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic              if_req;
   logic [AW-1:0]     if_addr;
   logic              if_ack;
   logic [DW-1:0]     if_rdata;

   logic              d_req;
   logic              d_we;
   logic [AW-1:0]     d_addr;
   logic [DW/8-1:0]   d_be;
   logic [DW-1:0]     d_wdata;
   logic              d_ack;
   logic [DW-1:0]     d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [DW/8-1:0]   mem_be;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_be, d_wdata, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_be, d_wdata, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store requesters: IDLE -> ACCESS(LAT) -> DONE.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise data has fixed priority over fetch.
module mem_port_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int BW = DW / 8;
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            own_data_q;
   logic [AW-1:0]   mem_addr_q;
   logic [BW-1:0]   mem_be_q;
   logic [DW-1:0]   mem_wdata_q;
   logic            mem_we_q;
   logic            mem_en_q;
   logic            if_ack_q;
   logic            d_ack_q;
   logic            busy_q;
   logic [DW-1:0]   if_rdata_q;
   logic [DW-1:0]   d_rdata_q;
   logic            sel_data_d;

`ifdef MEM_ARB_RR_EN
   logic            last_data_q;

   // Tie goes to whichever requester was not served last.
   always_comb begin
      sel_data_d = bus.d_req & (~bus.if_req | ~last_data_q);
   end

   // Pointer tracks the most recent grant, contested or not.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_data_q <= 1'b1;
      end else if (state_q == IDLE && (bus.if_req || bus.d_req)) begin
         last_data_q <= sel_data_d;
      end
   end
`else
   // Data always wins a tie.
   always_comb begin
      sel_data_d = bus.d_req;
   end
`endif

   // Sequencer: latch the winner, run the memory for LAT cycles, then ack once.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         own_data_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         busy_q      <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  own_data_q <= sel_data_d;
                  if (sel_data_d) begin
                     mem_addr_q  <= bus.d_addr;
                     mem_be_q    <= bus.d_be;
                     mem_we_q    <= bus.d_we;
                     mem_wdata_q <= bus.d_wdata;
                  end else begin
                     mem_addr_q  <= bus.if_addr;
                     mem_be_q    <= '1;
                     mem_we_q    <= 1'b0;
                     mem_wdata_q <= '0;
                  end
                  cnt_q    <= CW'(LAT - 1);
                  mem_en_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ACCESS;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  if (!mem_we_q) begin
                     if (own_data_q) begin
                        d_rdata_q <= bus.mem_rdata;
                     end else begin
                        if_rdata_q <= bus.mem_rdata;
                     end
                  end
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if_ack_q <= ~own_data_q;
                  d_ack_q  <= own_data_q;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            DONE: begin
               if_ack_q <= 1'b0;
               d_ack_q  <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               if_ack_q <= 1'b0;
               d_ack_q  <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants, a monitor checks
// every memory cycle and every ack against them. Works with or without MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;

   typedef struct {
      bit          is_data;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   pass_cnt;
   int   total_cnt;
   exp_t exp_q[$];

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return (a == 32'h0040_0000) ? 32'h3C01_0040 : (a ^ 32'hA5A5_A5A5);
   endfunction

   assign bus.mem_rdata = rd_model(bus.mem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endfunction

   task automatic push(input bit d, input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
      exp_t e;
      e.is_data = d; e.we = we; e.addr = a; e.be = be; e.wdata = wd;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack();
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 64) begin
         @(negedge clk);
         got = bus.if_ack | bus.d_ack;
         n++;
      end
      check("ack_seen", 128'(got), 128'(1));
   endtask

   task automatic wait_mem_en();
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 64) begin
         @(negedge clk);
         got = bus.mem_en;
         n++;
      end
      check("mem_en_seen", 128'(got), 128'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, 128'({bus.if_ack, bus.d_ack, bus.busy, bus.mem_en, bus.mem_we, bus.mem_be}),
            128'(0));
      check({tag, "_data"}, {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata}, 128'(0));
   endtask

   // Monitor: sampled 1 time unit after each rising edge.
   initial begin : monitor
      exp_t        e;
      int          access_cnt;
      logic [31:0] m_if;
      logic [31:0] m_d;
      access_cnt = 0; m_if = 32'h0; m_d = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            exp_q.delete();
            access_cnt = 0; m_if = 32'h0; m_d = 32'h0;
         end else begin
            if (bus.mem_en) begin
               check("access_expected", 128'(exp_q.size() != 0), 128'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q[0];
                  check("mem_bus",
                        128'({bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_we ? bus.mem_wdata : 32'h0}),
                        128'({e.addr, e.be, e.we, e.we ? e.wdata : 32'h0}));
                  check("busy_access", 128'(bus.busy), 128'(1));
               end
               access_cnt++;
            end
            if (bus.if_ack || bus.d_ack) begin
               check("ack_expected", 128'(exp_q.size() != 0), 128'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("ack_owner", 128'({bus.if_ack, bus.d_ack}), 128'(e.is_data ? 2'b01 : 2'b10));
                  check("access_cycles", 128'(access_cnt), 128'(LAT));
                  check("done_en_busy", 128'({bus.mem_en, bus.busy}), 128'(2'b01));
                  if (!e.we) begin
                     if (e.is_data) m_d = rd_model(e.addr);
                     else m_if = rd_model(e.addr);
                  end
                  check("rdata", 128'({bus.if_rdata, bus.d_rdata}), 128'({m_if, m_d}));
               end
               access_cnt = 0;
            end
         end
      end
   end

   initial begin : stimulus
      int t0;
      int prev;
      cyc = 0; pass_cnt = 0; total_cnt = 0;
      reset       = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0040_0000;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h1001_0008;
      bus.d_be    = 4'hF;
      bus.d_wdata = 32'h1111_1111;

      // Reset held two cycles with both requests high.
      @(posedge clk); @(negedge clk);
      check_reset_outputs("reset_c1");
      @(posedge clk); @(negedge clk);
      check_reset_outputs("reset_c2");

      // Release with both requests held for four transactions.
      reset = 1'b1;
`ifdef MEM_ARB_RR_EN
      push(1'b0, 1'b0, 32'h0040_0000, 4'hF, 32'h0);
      push(1'b1, 1'b0, 32'h1001_0008, 4'hF, 32'h0);
      push(1'b0, 1'b0, 32'h0040_0000, 4'hF, 32'h0);
      push(1'b1, 1'b0, 32'h1001_0008, 4'hF, 32'h0);
`else
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 32'h1001_0008, 4'hF, 32'h0);
`endif
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ack();
         if (i > 0) check("b2b_spacing", 128'(cyc - prev), 128'(LAT + 2));
         prev = cyc;
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      repeat (2) @(negedge clk);

      // Fetch read latency.
      bus.if_addr = 32'h0040_0000;
      bus.if_req  = 1'b1;
      t0 = cyc;
      push(1'b0, 1'b0, 32'h0040_0000, 4'hF, 32'h0);
      wait_ack();
      bus.if_req = 1'b0;
      check("fetch_latency", 128'(cyc - t0), 128'(LAT + 1));
      check("fetch_rdata", 128'(bus.if_rdata), 128'(32'h3C01_0040));
      repeat (2) @(negedge clk);

      // Data write: d_rdata must stay at its last loaded value.
      bus.d_addr  = 32'h1001_0004;
      bus.d_be    = 4'b0011;
      bus.d_wdata = 32'hDEAD_BEEF;
      bus.d_we    = 1'b1;
      bus.d_req   = 1'b1;
      t0 = cyc;
      push(1'b1, 1'b1, 32'h1001_0004, 4'b0011, 32'hDEAD_BEEF);
      wait_ack();
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      check("write_latency", 128'(cyc - t0), 128'(LAT + 1));
      repeat (2) @(negedge clk);

      // Inputs changed during ACCESS must not reach the memory.
      bus.d_addr  = 32'h1001_0010;
      bus.d_be    = 4'hF;
      bus.d_we    = 1'b0;
      bus.d_req   = 1'b1;
      push(1'b1, 1'b0, 32'h1001_0010, 4'hF, 32'h0);
      wait_mem_en();
      bus.d_addr  = 32'h2000_0000;
      bus.d_be    = 4'h1;
      bus.d_we    = 1'b1;
      bus.d_wdata = 32'h5555_5555;
      wait_ack();
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in the first ACCESS cycle abandons the fetch with no ack.
      bus.if_addr = 32'h0040_0100;
      bus.if_req  = 1'b1;
      push(1'b0, 1'b0, 32'h0040_0100, 4'hF, 32'h0);
      wait_mem_en();
      reset      = 1'b0;
      bus.if_req = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort");
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_no_ack_pending", 128'(exp_q.size()), 128'(0));

      // A request dropped mid-transaction still completes.
      bus.d_addr = 32'h1001_0020;
      bus.d_be   = 4'hF;
      bus.d_req  = 1'b1;
      push(1'b1, 1'b0, 32'h1001_0020, 4'hF, 32'h0);
      wait_mem_en();
      bus.d_req = 1'b0;
      wait_ack();
      repeat (2) @(negedge clk);

      // Tie after a mid-transaction reset: pointer is back at its reset value.
      bus.if_addr = 32'h0040_0000;
      bus.d_addr  = 32'h1001_0030;
      bus.if_req  = 1'b1;
      bus.d_req   = 1'b1;
`ifdef MEM_ARB_RR_EN
      push(1'b0, 1'b0, 32'h0040_0000, 4'hF, 32'h0);
`else
      push(1'b1, 1'b0, 32'h1001_0030, 4'hF, 32'h0);
`endif
      wait_ack();
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      repeat (4) @(negedge clk);
      check("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
